// File: rtl/simple_fixed_2_if.sv
// Operand, write-back and forwarding signals of the Simple Fixed 2 pipe.
// Vectors use big-endian bit numbering: bit 0 is the MSB.
interface simple_fixed_2_if;
    logic [0:10]  op_code;
    logic [2:0]   instr_format;
    logic [0:6]   dest_reg_addr;
    logic [0:127] src_reg_a;
    logic [0:127] src_reg_b;
    logic [0:17]  imm_value;
    logic         enable_reg_write;
    logic         branch_is_taken;
    logic [0:127] wb_data;
    logic [0:6]   wb_reg_addr;
    logic         wb_enable_reg_write;
    logic [0:127] delayed_rt_data;
    logic [0:6]   delayed_rt_addr;
    logic         delayed_enable_reg_write;

    modport slave (
        input  op_code, instr_format, dest_reg_addr, src_reg_a, src_reg_b,
        input  imm_value, enable_reg_write, branch_is_taken,
        output wb_data, wb_reg_addr, wb_enable_reg_write,
        output delayed_rt_data, delayed_rt_addr, delayed_enable_reg_write
    );

    modport master (
        output op_code, instr_format, dest_reg_addr, src_reg_a, src_reg_b,
        output imm_value, enable_reg_write, branch_is_taken,
        input  wb_data, wb_reg_addr, wb_enable_reg_write,
        input  delayed_rt_data, delayed_rt_addr, delayed_enable_reg_write
    );
endinterface

// File: rtl/simple_fixed_2.sv
// Simple Fixed 2 pipe: 3-stage SIMD halfword/word shift-left and rotate-left.
// Optional macro SIMPLE_FIXED_2_ILLEGAL_SQUASH_EN squashes the write enable of unrecognised opcodes.
module simple_fixed_2 (
    input  logic            clock,
    input  logic            reset,
    simple_fixed_2_if.slave bus
);
    localparam logic [0:10] OP_SHLH  = 11'b00001011111;
    localparam logic [0:10] OP_SHLHI = 11'b00001111111;
    localparam logic [0:10] OP_SHL   = 11'b00001011011;
    localparam logic [0:10] OP_SHLI  = 11'b00001111011;
    localparam logic [0:10] OP_ROTH  = 11'b00001011100;
    localparam logic [0:10] OP_ROTHI = 11'b00001111100;
    localparam logic [0:10] OP_ROT   = 11'b00001011000;
    localparam logic [0:10] OP_ROTI  = 11'b00001111000;
    localparam logic [0:10] OP_NOP   = 11'b01000000001;

    logic w_is_shlh, w_is_shlhi, w_is_shl, w_is_shli;
    logic w_is_roth, w_is_rothi, w_is_rot, w_is_roti;
    logic w_is_nop, w_known, w_we_allowed, w_we;
    logic w_imm_op, w_half_op, w_word_op, w_half_rot, w_word_rot;
    logic [5:0]   w_i7_cnt;
    logic [0:127] w_res_h;
    logic [0:127] w_res_w;
    logic [0:127] w_result;
    logic         w_unused;

    assign w_is_shlh  = (bus.op_code == OP_SHLH);
    assign w_is_shlhi = (bus.op_code == OP_SHLHI);
    assign w_is_shl   = (bus.op_code == OP_SHL);
    assign w_is_shli  = (bus.op_code == OP_SHLI);
    assign w_is_roth  = (bus.op_code == OP_ROTH);
    assign w_is_rothi = (bus.op_code == OP_ROTHI);
    assign w_is_rot   = (bus.op_code == OP_ROT);
    assign w_is_roti  = (bus.op_code == OP_ROTI);
    assign w_is_nop   = (bus.op_code == OP_NOP) || (bus.op_code == 11'b0);

    // The opcode alone identifies the immediate forms, so instr_format is not needed to pick counts.
    assign w_imm_op   = w_is_shlhi | w_is_shli | w_is_rothi | w_is_roti;
    assign w_half_rot = w_is_roth | w_is_rothi;
    assign w_word_rot = w_is_rot | w_is_roti;
    assign w_half_op  = w_is_shlh | w_is_shlhi | w_half_rot;
    assign w_word_op  = w_is_shl | w_is_shli | w_word_rot;
    assign w_known    = w_half_op | w_word_op;

    // Low six bits of the signed I7 field; every count is taken as unsigned.
    assign w_i7_cnt = bus.imm_value[12:17];
    assign w_unused = ^{bus.instr_format, bus.imm_value[0:11], bus.src_reg_b};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_half
            logic [15:0] w_ra;
            logic [4:0]  w_sh_cnt;
            logic [3:0]  w_rot_cnt;
            logic [15:0] w_shl;
            logic [31:0] w_rot_wide;

            assign w_ra       = bus.src_reg_a[16*gi +: 16];
            assign w_sh_cnt   = w_imm_op ? w_i7_cnt[4:0] : bus.src_reg_b[16*gi+11 +: 5];
            assign w_rot_cnt  = w_imm_op ? w_i7_cnt[3:0] : bus.src_reg_b[16*gi+12 +: 4];
            assign w_shl      = w_sh_cnt[4] ? 16'h0000 : (w_ra << w_sh_cnt[3:0]);
            assign w_rot_wide = {w_ra, w_ra} << w_rot_cnt;
            assign w_res_h[16*gi +: 16] = w_half_rot ? w_rot_wide[31:16] : w_shl;
        end

        for (gi = 0; gi < 4; gi++) begin : g_word
            logic [31:0] w_ra;
            logic [5:0]  w_sh_cnt;
            logic [4:0]  w_rot_cnt;
            logic [31:0] w_shl;
            logic [63:0] w_rot_wide;

            assign w_ra       = bus.src_reg_a[32*gi +: 32];
            assign w_sh_cnt   = w_imm_op ? w_i7_cnt : bus.src_reg_b[32*gi+26 +: 6];
            assign w_rot_cnt  = w_imm_op ? w_i7_cnt[4:0] : bus.src_reg_b[32*gi+27 +: 5];
            assign w_shl      = w_sh_cnt[5] ? 32'h0000_0000 : (w_ra << w_sh_cnt[4:0]);
            assign w_rot_wide = {w_ra, w_ra} << w_rot_cnt;
            assign w_res_w[32*gi +: 32] = w_word_rot ? w_rot_wide[63:32] : w_shl;
        end
    endgenerate

    assign w_result = w_half_op ? w_res_h : (w_word_op ? w_res_w : 128'h0);

`ifdef SIMPLE_FIXED_2_ILLEGAL_SQUASH_EN
    assign w_we_allowed = w_known;
`else
    assign w_we_allowed = !w_is_nop;
`endif
    assign w_we = bus.enable_reg_write & w_we_allowed & ~bus.branch_is_taken;

    logic [0:127] r_s1_data, r_s2_data, r_s3_data;
    logic [0:6]   r_s1_addr, r_s2_addr, r_s3_addr;
    logic         r_s1_we, r_s2_we, r_s3_we;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_data <= '0;
            r_s1_addr <= '0;
            r_s1_we   <= 1'b0;
            r_s2_data <= '0;
            r_s2_addr <= '0;
            r_s2_we   <= 1'b0;
            r_s3_data <= '0;
            r_s3_addr <= '0;
            r_s3_we   <= 1'b0;
        end else begin
            r_s1_data <= w_result;
            r_s1_addr <= bus.dest_reg_addr;
            r_s1_we   <= w_we;
            r_s2_data <= r_s1_data;
            r_s2_addr <= r_s1_addr;
            r_s2_we   <= r_s1_we;
            r_s3_data <= r_s2_data;
            r_s3_addr <= r_s2_addr;
            r_s3_we   <= r_s2_we;
        end
    end

    assign bus.delayed_rt_data          = r_s1_data;
    assign bus.delayed_rt_addr          = r_s1_addr;
    assign bus.delayed_enable_reg_write = r_s1_we;
    assign bus.wb_data                  = r_s3_data;
    assign bus.wb_reg_addr              = r_s3_addr;
    assign bus.wb_enable_reg_write      = r_s3_we;
endmodule

// File: tb/tb_simple_fixed_2.sv
// Directed bench for simple_fixed_2: lane-arithmetic reference model with per-cycle
// compare of the forwarding tap and write-back, plus literal expectations.
module tb_simple_fixed_2;
    localparam logic [10:0] SHLH  = 11'b00001011111;
    localparam logic [10:0] SHLHI = 11'b00001111111;
    localparam logic [10:0] SHL   = 11'b00001011011;
    localparam logic [10:0] SHLI  = 11'b00001111011;
    localparam logic [10:0] ROTH  = 11'b00001011100;
    localparam logic [10:0] ROTHI = 11'b00001111100;
    localparam logic [10:0] ROT   = 11'b00001011000;
    localparam logic [10:0] ROTI  = 11'b00001111000;
    localparam logic [10:0] NOP   = 11'b01000000001;
    localparam logic [10:0] BAD   = 11'b11111111111;
    localparam logic [2:0]  RR    = 3'b000;
    localparam logic [2:0]  RI7   = 3'b010;

    typedef struct {
        logic [127:0] data;
        logic [6:0]   addr;
        logic         we;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t hist[$];

    simple_fixed_2_if sif();

    simple_fixed_2 dut (
        .clock (clk),
        .reset (rst),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    // Reference: each lane computed with plain integer arithmetic.
    function automatic exp_t model(logic [10:0] op, logic [127:0] a, logic [127:0] b,
                                   logic [17:0] imm, logic [6:0] addr, logic we, logic br);
        exp_t e;
        int   kind;
        bit   use_imm;
        bit   nop;
        longint unsigned x, y, c, r;
        kind = 0;
        use_imm = 1'b0;
        nop = (op == NOP) || (op == 11'd0);
        case (op)
            SHLH:  kind = 1;
            SHLHI: begin kind = 1; use_imm = 1'b1; end
            ROTH:  kind = 2;
            ROTHI: begin kind = 2; use_imm = 1'b1; end
            SHL:   kind = 3;
            SHLI:  begin kind = 3; use_imm = 1'b1; end
            ROT:   kind = 4;
            ROTI:  begin kind = 4; use_imm = 1'b1; end
            default: kind = 0;
        endcase
        e.data = '0;
        e.addr = addr;
        if (kind == 1 || kind == 2) begin
            for (int j = 0; j < 8; j++) begin
                x = a[127-16*j -: 16];
                y = use_imm ? longint'(imm[6:0]) : longint'(b[127-16*j -: 16]);
                if (kind == 1) begin
                    c = y % 32;
                    r = (c > 15) ? 0 : ((x << c) % 65536);
                end else begin
                    c = y % 16;
                    r = (c == 0) ? x : (((x << c) | (x >> (16 - c))) % 65536);
                end
                e.data[127-16*j -: 16] = r[15:0];
            end
        end else if (kind == 3 || kind == 4) begin
            for (int j = 0; j < 4; j++) begin
                x = a[127-32*j -: 32];
                y = use_imm ? longint'(imm[6:0]) : longint'(b[127-32*j -: 32]);
                if (kind == 3) begin
                    c = y % 64;
                    r = (c > 31) ? 0 : ((x << c) % 64'h1_0000_0000);
                end else begin
                    c = y % 32;
                    r = (c == 0) ? x : (((x << c) | (x >> (32 - c))) % 64'h1_0000_0000);
                end
                e.data[127-32*j -: 32] = r[31:0];
            end
        end
        if (kind != 0)
            e.we = we & ~br;
        else if (nop)
            e.we = 1'b0;
        else begin
`ifdef SIMPLE_FIXED_2_ILLEGAL_SQUASH_EN
            e.we = 1'b0;
`else
            e.we = we & ~br;
`endif
        end
        return e;
    endfunction

    // History of expected stage contents, newest first; reset empties the pipe.
    initial begin
        for (int i = 0; i < 3; i++) hist.push_back('{data: '0, addr: '0, we: 1'b0});
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            for (int i = 0; i < 3; i++) hist.push_back('{data: '0, addr: '0, we: 1'b0});
        end else begin
            hist.push_front(model(sif.op_code, sif.src_reg_a, sif.src_reg_b, sif.imm_value,
                                  sif.dest_reg_addr, sif.enable_reg_write, sif.branch_is_taken));
            hist.delete(3);
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e1, e3;
        if (rst) begin
            e1 = '{data: '0, addr: '0, we: 1'b0};
            e3 = e1;
        end else begin
            e1 = hist[0];
            e3 = hist[2];
        end
        chk("cyc_delayed_data", sif.delayed_rt_data, e1.data);
        chk("cyc_delayed_addr", 128'(sif.delayed_rt_addr), 128'(e1.addr));
        chk("cyc_delayed_we", 128'(sif.delayed_enable_reg_write), 128'(e1.we));
        chk("cyc_wb_data", sif.wb_data, e3.data);
        chk("cyc_wb_addr", 128'(sif.wb_reg_addr), 128'(e3.addr));
        chk("cyc_wb_we", 128'(sif.wb_enable_reg_write), 128'(e3.we));
    end

    task automatic drive(input logic [10:0] op, input logic [2:0] fmt, input logic [6:0] addr,
                         input logic [127:0] a, input logic [127:0] b, input logic [17:0] imm,
                         input logic we, input logic br);
        sif.op_code          = op;
        sif.instr_format     = fmt;
        sif.dest_reg_addr    = addr;
        sif.src_reg_a        = a;
        sif.src_reg_b        = b;
        sif.imm_value        = imm;
        sif.enable_reg_write = we;
        sif.branch_is_taken  = br;
    endtask

    task automatic issue(input logic [10:0] op, input logic [2:0] fmt, input logic [6:0] addr,
                         input logic [127:0] a, input logic [127:0] b, input logic [17:0] imm,
                         input logic we, input logic br);
        drive(op, fmt, addr, a, b, imm, we, br);
        $display("issue op=%b fmt=%b rt=%0d ra=%h rb=%h imm=%h we=%0b br=%0b",
                 op, fmt, addr, a, b, imm, we, br);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        issue(11'd0, RR, 7'd0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic expect_wb(input string name, input logic [127:0] d, input logic [6:0] addr,
                             input logic we);
        chk({name, "_data"}, sif.wb_data, d);
        chk({name, "_addr"}, 128'(sif.wb_reg_addr), 128'(addr));
        chk({name, "_we"}, 128'(sif.wb_enable_reg_write), 128'(we));
    endtask

    initial begin
        logic [10:0]  ops [8];
        int           cnts [8];
        logic [127:0] pat;
        ops  = '{SHLH, SHLHI, ROTH, ROTHI, SHL, SHLI, ROT, ROTI};
        cnts = '{0, 1, 7, 15, 16, 31, 32, 63};
        pat  = 128'h0123456789ABCDEF_FEDCBA9876543210;

        drive(11'd0, RR, 7'd0, '0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        expect_wb("reset_hold", '0, 7'd0, 1'b0);
        chk("reset_hold_delayed", sif.delayed_rt_data, '0);
        #2 rst = 1'b0;

        // shlh by 1: first-issue latency
        issue(SHLH, RR, 7'd3, {8{16'h8001}}, {8{16'h0001}}, '0, 1'b1, 1'b0);
        chk("shlh_delayed", sif.delayed_rt_data, {8{16'h0002}});
        idle();
        expect_wb("shlh_not_yet", '0, 7'd0, 1'b0);
        idle();
        expect_wb("shlh_wb", {8{16'h0002}}, 7'd3, 1'b1);

        // counts just past lane width
        issue(SHLH, RR, 7'd4, {8{16'hFFFF}}, {8{16'h0010}}, '0, 1'b1, 1'b0);
        issue(SHL, RR, 7'd5, {4{32'hFFFFFFFF}}, {4{32'h00000020}}, '0, 1'b1, 1'b0);
        idle();
        expect_wb("shlh16", '0, 7'd4, 1'b1);
        idle();
        expect_wb("shl32", '0, 7'd5, 1'b1);

        issue(ROT, RR, 7'd6, {4{32'h80000001}}, {4{32'h00000001}}, '0, 1'b1, 1'b0);
        issue(ROTH, RR, 7'd7, {8{16'h1234}}, {8{16'h0004}}, '0, 1'b1, 1'b0);
        idle();
        expect_wb("rot1", {4{32'h00000003}}, 7'd6, 1'b1);
        idle();
        expect_wb("roth4", {8{16'h2341}}, 7'd7, 1'b1);

        issue(SHLI, RI7, 7'd8, {4{32'h00000001}}, '0, 18'd5, 1'b1, 1'b0);
        issue(ROTHI, RI7, 7'd9, {8{16'h8001}}, '0, 18'd5, 1'b1, 1'b0);
        issue(SHLI, RI7, 7'd10, {4{32'hFFFFFFFF}}, '0, 18'h0007F, 1'b1, 1'b0);
        expect_wb("shli5", {4{32'h00000020}}, 7'd8, 1'b1);
        idle();
        expect_wb("rothi5", {8{16'h0030}}, 7'd9, 1'b1);
        idle();
        expect_wb("shli_neg", '0, 7'd10, 1'b1);

        // back-to-back nop/shlh; forwarding tap one edge after issue
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                issue(NOP, RR, 7'(20 + k), {8{16'hFFFF}}, {8{16'h0001}}, '0, 1'b1, 1'b0);
                chk("alt_nop_delayed_we", 128'(sif.delayed_enable_reg_write), 128'(0));
                chk("alt_nop_delayed_addr", 128'(sif.delayed_rt_addr), 128'(20 + k));
            end else begin
                issue(SHLH, RR, 7'(20 + k), {8{16'h4001}}, {8{16'h0001}}, '0, 1'b1, 1'b0);
                chk("alt_shlh_delayed", sif.delayed_rt_data, {8{16'h8002}});
            end
        end
        idle();
        idle();

        // squashed rot between two live instructions
        issue(SHLH, RR, 7'd30, {8{16'h0001}}, {8{16'h0002}}, '0, 1'b1, 1'b0);
        issue(ROT, RR, 7'd31, {4{32'h80000001}}, {4{32'h00000001}}, '0, 1'b1, 1'b1);
        issue(SHLH, RR, 7'd32, {8{16'h0001}}, {8{16'h0003}}, '0, 1'b1, 1'b0);
        expect_wb("br_before", {8{16'h0004}}, 7'd30, 1'b1);
        idle();
        expect_wb("br_squashed", {4{32'h00000003}}, 7'd31, 1'b0);
        idle();
        expect_wb("br_after", {8{16'h0008}}, 7'd32, 1'b1);

        issue(BAD, RR, 7'd40, {8{16'hFFFF}}, {8{16'h0001}}, '0, 1'b1, 1'b0);
        idle();
        idle();
`ifdef SIMPLE_FIXED_2_ILLEGAL_SQUASH_EN
        expect_wb("illegal", '0, 7'd40, 1'b0);
`else
        expect_wb("illegal", '0, 7'd40, 1'b1);
`endif

        // count sweep across every operation
        foreach (ops[i]) begin
            foreach (cnts[j]) begin
                issue(ops[i], (i % 2 == 1) ? RI7 : RR, 7'(i * 8 + j), pat,
                      (i < 4) ? {8{16'(cnts[j])}} : {4{32'(cnts[j])}}, 18'(cnts[j]),
                      1'b1, 1'b0);
            end
        end

        // reset in flight
        issue(ROT, RR, 7'd50, {4{32'h80000001}}, {4{32'h00000001}}, '0, 1'b1, 1'b0);
        issue(SHLH, RR, 7'd51, {8{16'h8001}}, {8{16'h0001}}, '0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        expect_wb("midreset", '0, 7'd0, 1'b0);
        chk("midreset_delayed", sif.delayed_rt_data, '0);
        chk("midreset_delayed_we", 128'(sif.delayed_enable_reg_write), 128'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        issue(SHLH, RR, 7'd52, {8{16'h0003}}, {8{16'h0001}}, '0, 1'b1, 1'b0);
        idle();
        expect_wb("after_reset_lost", '0, 7'd0, 1'b0);
        idle();
        expect_wb("after_reset_first", {8{16'h0006}}, 7'd52, 1'b1);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simple_fixed_2.md
Name: simple_fixed_2

Overview:
- Simple Fixed 2 execution pipe of the SPU: a pipelined, 128-bit SIMD halfword/word shift-left and rotate-left unit.
- Receives decoded operands from the register-file/forwarding stage.
- Presents results with destination address and write enable to write-back.
- Exposes a first-stage forwarding tap.

Parameters:
None (fixed 128-bit datapath, 3-stage pipeline).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op_code  in  11 [0:10]  decoded opcode; shorter formats left-justified
- instr_format  in  3  format: 000 = RR, 010 = RI7; others are treated as RR
- dest_reg_addr  in  7 [0:6]  destination register (rt)
- src_reg_a  in  128 [0:127]  operand ra
- src_reg_b  in  128 [0:127]  operand rb (shift/rotate counts)
- imm_value  in  18 [0:17]  immediate; RI7 uses imm_value[11:17] as signed I7
- enable_reg_write  in  1  instruction writes the register file
- wb_data  out  128  stage-3 result
- wb_reg_addr  out  7  stage-3 destination
- wb_enable_reg_write  out  1  stage-3 write enable
- branch_is_taken  in  1  squash the instruction being issued this cycle
- delayed_rt_data  out  128  stage-1 result (forwarding)
- delayed_rt_addr  out  7  stage-1 destination
- delayed_enable_reg_write  out  1  stage-1 write enable

Behaviour:
- Big-endian lanes: bit 0 is the MSB. Word i = bits 32i..32i+31; halfword j = bits 16j..16j+15.
- Opcode decode (all lanes in parallel):
  - shlh 00001011111: count = rb halfword bits 11:15 (5 bits); result = ra << count; count > 15 gives 0.
  - shlhi 00001111111: count = I7 low 5 bits; same rule as shlh.
  - shl 00001011011: count = rb word bits 26:31 (6 bits); count > 31 gives 0.
  - shli 00001111011: count = I7 low 6 bits; same rule as shl.
  - roth 00001011100: rotate left by rb halfword bits 12:15.
  - rothi 00001111100: rotate left by I7 low 4 bits.
  - rot 00001011000: rotate left by rb word bits 27:31.
  - roti 00001111000: rotate left by I7 low 5 bits.
  - Shifts fill vacated bits with zeros.
- nop (01000000001) and 00000000000:
  - result 0, write enable forced 0.
  - dest_reg_addr still propagates.
- Any other opcode: result 0; write-enable handling is set by the optional feature below.
- Pipeline:
  - Result is computed combinationally and captured on rising edge N into stage 1 (drives delayed_rt_*).
  - Moves to stage 2 at edge N+1 and stage 3 at edge N+2.
  - Stage 3 drives wb_*, so wb_* is valid after edge N+2: latency 3 clocks.
  - One new instruction may be accepted per cycle; no stalls.
- branch_is_taken high at edge N: the stage-1 captured write enable is forced 0. Data and address are still captured. Older stages are unaffected.
- Reset:
  - Asynchronous; all stage registers clear to data 0, address 0, enable 0, so every output reads 0 while reset is high.
  - Reset asserted mid-operation discards all in-flight instructions.
  - First capture occurs on the first rising edge after reset deasserts.
- All count fields are unsigned. A negative I7 contributes its low bits (e.g. I7 = 0x7F gives count 63 for shli, result 0).

Optional Feature:
- Macro: SIMPLE_FIXED_2_ILLEGAL_SQUASH_EN
- Defined: an unrecognised opcode (not in the table above and not nop/0) forces stage-1 write enable to 0 and result to 0.
- Undefined: unrecognised opcode gives result 0, and enable_reg_write passes through unchanged.

Test Plan:
- shlh, every ra halfword 0x8001, every rb halfword 0x0001 -> wb_data all halfwords 0x0002, wb_reg_addr 3, wb_enable_reg_write 1, exactly 3 edges after issue.
- shlh with rb halfwords 0x0010 -> all halfwords 0 (count 16). shl with rb word 0x00000020 -> all words 0.
- rot, ra words 0x80000001, rb words 1 -> words 0x00000003. roth, ra 0x1234 per halfword, rb 0x0004 -> 0x2341.
- RI7 with imm_value 5:
  - shli, ra words 0x00000001 -> 0x00000020.
  - rothi, ra halfwords 0x8001 -> 0x0030.
  - shli with I7 = 0x7F -> 0.
- Alternate nop (01000000001) and shlh every cycle -> nop slots give wb_enable_reg_write 0 and wb_data 0. delayed_rt_* shows each result 1 edge after issue.
- branch_is_taken = 1 during a rot issue -> that result reaches wb with enable 0, neighbouring instructions unaffected. Assert reset mid-stream -> all outputs 0 immediately, in-flight results lost.
